// File: rtl/chip_sp_pkg.sv
// Shared types and constants for the character-stream UART transmitter.
//   tx_state_t : transmitter FSM states
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   LINE_IDLE  : level of the serial line when nothing is being sent
package chip_sp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        LINE_IDLE  = 1'b1;

endpackage

// File: rtl/chip_sp_sync_fifo.sv
// Synchronous FIFO with show-ahead read: the head entry is on rdata whenever
// the FIFO is not empty.
//   clk, reset : clock and asynchronous active-low reset
//   push/wdata : write wdata on the clock edge (ignored when full)
//   pop        : advance the head on the clock edge (ignored when empty)
//   rdata      : current head entry
//   full/empty : occupancy flags
//   level      : number of entries held
module chip_sp_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers carry one extra wrap bit: equal addresses with differing wrap
    // bits means full, fully equal pointers means empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/chip_sp_uart_tx.sv
// Buffers the character generator's byte stream and serialises each byte as
// an 8N1 UART frame, LSB first.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset; aborts any frame in flight
//   in_data    : character byte from the generator
//   in_valid   : in_data valid this cycle
//   in_ready   : FIFO not full; a byte is taken when in_valid & in_ready
//   tx         : registered serial line, idle high
//   busy       : high while a frame (start, data or stop) is on the line
//   fifo_level : bytes currently waiting in the FIFO
module chip_sp_uart_tx
    import chip_sp_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t         state;
    tx_state_t         state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_n;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_n;
    logic              tx_r;
    logic              tx_n;
    logic              bit_end;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    chip_sp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_end = (cnt == CNT_LAST);
    assign busy    = (state != IDLE);
    assign tx      = tx_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= LINE_IDLE;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_r    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + CNT_ONE;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx_r;
        fifo_pop  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = LINE_IDLE;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_rdata;
                    tx_n     = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        tx_n    = LINE_IDLE;
                        state_n = STOP;
                    end else begin
                        // Next bit comes from the pre-shift position 1 so the
                        // registered tx lines up with the shifted register.
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        fifo_pop = 1'b1;
                        shift_n  = fifo_rdata;
                        tx_n     = 1'b0;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = LINE_IDLE;
            end
        endcase
    end

endmodule
